// File: rtl/case_conv_pkg.sv
// Shared encodings for the case-conversion stream: mode values, ASCII
// letter-range constants and the skid-buffer state type.
package case_conv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } conv_mode_e;

  localparam logic [7:0] UC_FIRST   = 8'h41;
  localparam logic [7:0] UC_LAST    = 8'h5A;
  localparam logic [7:0] LC_FIRST   = 8'h61;
  localparam logic [7:0] LC_LAST    = 8'h7A;
  localparam logic [7:0] CASE_DELTA = 8'h20;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

  // Number of set bits in a lane mask of up to 16 lanes.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/case_conv_lane.sv
// Combinational single-character case converter; a disabled lane or a
// byte outside the letter ranges always passes through untouched.
module case_conv_lane
  import case_conv_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic [1:0] i_mode,
  input  logic       i_keep,
  output logic [7:0] o_byte,
  output logic       o_changed
);

  logic w_is_upper;
  logic w_is_lower;

  always_comb begin
    w_is_upper = (i_byte >= UC_FIRST) && (i_byte <= UC_LAST);
    w_is_lower = (i_byte >= LC_FIRST) && (i_byte <= LC_LAST);
    o_byte     = i_byte;
    if (i_keep) begin
      case (conv_mode_e'(i_mode))
        MODE_UPPER:  if (w_is_lower) o_byte = i_byte - CASE_DELTA;
        MODE_LOWER:  if (w_is_upper) o_byte = i_byte + CASE_DELTA;
        MODE_TOGGLE: begin
          if (w_is_lower)      o_byte = i_byte - CASE_DELTA;
          else if (w_is_upper) o_byte = i_byte + CASE_DELTA;
        end
        default: ;
      endcase
    end
    o_changed = (o_byte != i_byte);
  end

endmodule

// File: rtl/case_conv_stream.sv
// Streaming ASCII case converter: per-lane conversion at the input, a
// 2-entry skid buffer with registered in_ready, and a saturating counter.
module case_conv_stream
  import case_conv_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [LANES-1:0]     in_keep,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [LANES-1:0]     out_keep,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     conv_cnt
);

  localparam int unsigned SUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  skid_state_e r_state;
  skid_state_e w_state_nxt;
  logic        r_in_ready;

  logic [8*LANES-1:0] r_head_data;
  logic [LANES-1:0]   r_head_keep;
  logic [8*LANES-1:0] r_skid_data;
  logic [LANES-1:0]   r_skid_keep;
  logic [CNT_W-1:0]   r_cnt;

  logic [8*LANES-1:0] w_conv_data;
  logic [LANES-1:0]   w_changed;
  logic [15:0]        w_chg_ext;
  logic [4:0]         w_inc;
  logic [SUM_W-1:0]   w_sum;

  logic w_accept;
  logic w_drain;
  logic w_load_head_in;
  logic w_load_head_skid;
  logic w_load_skid;

  // Conversion happens on the way in, so a buffered beat already carries the
  // mode that was live when it was accepted.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    case_conv_lane u_lane (
      .i_byte    (in_data[8*gi +: 8]),
      .i_mode    (mode),
      .i_keep    (in_keep[gi]),
      .o_byte    (w_conv_data[8*gi +: 8]),
      .o_changed (w_changed[gi])
    );
  end

  assign w_chg_ext = 16'(w_changed);
  assign w_inc     = popcount16(w_chg_ext);
  assign w_sum     = SUM_W'(r_cnt) + SUM_W'(w_inc);

  always_comb begin
    w_accept         = in_valid && r_in_ready;
    w_drain          = (r_state != SKID_EMPTY) && out_ready;
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      SKID_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = SKID_ONE;
          w_load_head_in = 1'b1;
        end
      end
      SKID_ONE: begin
        case ({w_accept, w_drain})
          2'b10: begin
            w_state_nxt = SKID_FULL;
            w_load_skid = 1'b1;
          end
          2'b01: w_state_nxt = SKID_EMPTY;
          2'b11: w_load_head_in = 1'b1;
          default: ;
        endcase
      end
      SKID_FULL: begin
        if (w_drain) begin
          w_state_nxt      = SKID_ONE;
          w_load_head_skid = 1'b1;
        end
      end
      default: w_state_nxt = SKID_EMPTY;
    endcase
  end

  // in_ready is a flop fed from the next state, keeping out_ready off the
  // upstream ready path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= SKID_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != SKID_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head_data <= '0;
      r_head_keep <= '0;
      r_skid_data <= '0;
      r_skid_keep <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head_data <= w_conv_data;
        r_head_keep <= in_keep;
      end else if (w_load_head_skid) begin
        r_head_data <= r_skid_data;
        r_head_keep <= r_skid_keep;
      end
      if (w_load_skid) begin
        r_skid_data <= w_conv_data;
        r_skid_keep <= in_keep;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != SKID_EMPTY);
  assign out_data  = r_head_data;
  assign out_keep  = r_head_keep;
  assign conv_cnt  = r_cnt;

endmodule

// File: doc/case_conv_stream.md
CASE_CONV_STREAM -- requirements
Module: case_conv_stream

Interface
REQ-001 The module SHALL have parameter LANES, default 4: characters per beat, 1..16.
REQ-002 The module SHALL have parameter CNT_W, default 16: width of the converted-character counter.
REQ-003 Port clk SHALL be input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be input, 1 bit: reset, synchronous and active-low.
REQ-005 Port mode SHALL be input, 2 bits: 00 pass, 01 upper, 10 lower, 11 toggle-case.
REQ-006 Port in_valid SHALL be input, 1 bit: upstream beat valid.
REQ-007 Port in_ready SHALL be output, 1 bit: block can accept a beat.
REQ-008 Port in_data SHALL be input, 8*LANES bits: lane i = in_data[8i+7:8i].
REQ-009 Port in_keep SHALL be input, LANES bits: lane enable; a lane with keep=0 passes unchanged.
REQ-010 Port out_valid SHALL be output, 1 bit: output beat valid.
REQ-011 Port out_ready SHALL be input, 1 bit: downstream accepts the beat.
REQ-012 Port out_data SHALL be output, 8*LANES bits: converted characters.
REQ-013 Port out_keep SHALL be output, LANES bits: in_keep forwarded with its beat.
REQ-014 Port clr_cnt SHALL be input, 1 bit: synchronous clear of conv_cnt.
REQ-015 Port conv_cnt SHALL be output, CNT_W bits: count of characters actually modified; saturating.

Function
REQ-016 A beat SHALL transfer on the input when in_valid&&in_ready, and on the output when out_valid&&out_ready, both at the rising edge.
REQ-017 Per lane, upper mode SHALL map 0x61..0x7A to the value minus 0x20; all other values SHALL pass unchanged.
REQ-018 Per lane, lower mode SHALL map 0x41..0x5A to the value plus 0x20; all other values SHALL pass unchanged.
REQ-019 Toggle mode SHALL apply both REQ-017 and REQ-018; pass mode SHALL leave every byte unchanged.
REQ-020 Boundary bytes 0x40, 0x5B, 0x60, 0x7B and all bytes >=0x80 SHALL never change in any mode.
REQ-021 mode SHALL be sampled with each accepted beat; a mode change SHALL affect only beats accepted after it, never beats already buffered.
REQ-022 Latency SHALL be 1 cycle: a beat accepted at edge N SHALL be presented with out_valid=1 after edge N when the buffer was empty.
REQ-023 Buffering SHALL be a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-024 EMPTY SHALL go to ONE on an accepted input.
REQ-025 ONE SHALL go to FULL on accept without drain, to EMPTY on drain without accept, and stay ONE on simultaneous accept and drain.
REQ-026 FULL SHALL go to ONE on drain.
REQ-027 in_ready SHALL be registered, SHALL equal (state!=FULL), and SHALL have no combinational path from out_ready.
REQ-028 Beats SHALL leave in acceptance order; out_data, out_keep and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Full throughput SHALL be one beat per cycle when out_ready stays 1.
REQ-030 On each accepted beat, conv_cnt SHALL add the number of lanes with keep=1 whose byte changed (0..LANES).
REQ-031 conv_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 clr_cnt=1 SHALL load conv_cnt with 0 and SHALL override a same-cycle increment.

Reset
REQ-033 rst_n=0 at a rising edge SHALL set the state to EMPTY, out_valid=0, in_ready=0, out_data=0, out_keep=0 and conv_cnt=0.
REQ-034 in_ready SHALL rise on the first edge after rst_n returns to 1.
REQ-035 Reset mid-stream SHALL discard buffered beats with no partial output.

Structure
REQ-036 Package case_conv_pkg SHALL hold the mode encodings (MODE_PASS, MODE_UPPER, MODE_LOWER, MODE_TOGGLE), the letter-range constants 0x41/0x5A/0x61/0x7A/0x20 and the skid-state type.
REQ-037 Sub-module case_conv_lane SHALL be a combinational single-byte converter (inputs byte, mode, keep; outputs byte, changed), instantiated LANES times.

Verification
REQ-038 Bench SHALL cover: LANES=4, upper, in_data bytes "a{z@" (0x61,0x7B,0x7A,0x40), keep=1111 -> out 0x41,0x7B,0x5A,0x40 one cycle later; conv_cnt +2.
REQ-039 Bench SHALL cover: toggle, bytes 0x48,0x6D,0xEB,0x5B, keep=1111 -> 0x68,0x4D,0xEB,0x5B; conv_cnt +2.
REQ-040 Bench SHALL cover: lower, keep=0101, bytes 0x41,0x42,0x43,0x44 (lane0 first) -> 0x61,0x42,0x63,0x44; conv_cnt +2.
REQ-041 Bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> exactly 2 beats accepted, in_ready=0; out_ready=1 -> both beats drain in order, data unchanged while stalled.
REQ-042 Bench SHALL cover: CNT_W=4, stream of beats all lowercase in upper mode until 15 -> conv_cnt holds 15; clr_cnt with a same-cycle converting beat -> 0.
REQ-043 Bench SHALL cover: rst_n=0 while FULL -> next cycle out_valid=0, conv_cnt=0, in_ready=0; released -> in_ready=1 after one edge, no stale beat appears.
